// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// Computes diff = (a - b) mod 2^WIDTH and borrow = (a < b) over WIDTH shift
// cycles. All outputs come straight from flops.
//
// Timing for a start sampled at edge k:
//   edges k+1 .. k+WIDTH : one bit processed per edge (SHIFT)
//   edge  k+WIDTH        : enter DONE, diff/borrow take the final result
//   edge  k+WIDTH+1      : DONE -> IDLE, done pulses for the following cycle
//   edge  k+WIDTH+2      : earliest edge a new start is accepted
// This gives a WIDTH+1 cycle latency and a WIDTH+2 cycle back-to-back period.
// busy follows the FSM state (SHIFT/DONE), so it is already low in the cycle
// that carries the done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One full-subtractor bit; returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(
    input logic a0,
    input logic b0,
    input logic br
  );
    logic d;
    logic br_next;
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    return {br_next, d};
  endfunction

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [1:0]       bit_s;
  logic [WIDTH-1:0] res_next_s;

  // Current-bit arithmetic and the result register as it would look after this shift.
  always_comb begin
    bit_s      = sub_bit(a_sh_q[0], b_sh_q[0], br_q);
    res_next_s = {bit_s[0], res_q[WIDTH-1:1]};
  end

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Operands are captured only here, so start during SHIFT/DONE is inert.
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = W_ZERO;
          br_d    = 1'b0;
          cnt_d   = CNT_ZERO;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = res_next_s;
        br_d   = bit_s[1];
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed result as DONE is entered.
          diff_d   = res_next_s;
          borrow_d = bit_s[1];
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= W_ZERO;
      b_sh_q   <= W_ZERO;
      res_q    <= W_ZERO;
      br_q     <= 1'b0;
      cnt_q    <= CNT_ZERO;
      diff_q   <= W_ZERO;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results with their start time, a negedge monitor pops on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int PERIOD = 10;
  // done is seen at the negedge following edge k+W+1
  localparam int LAT_T = (W + 1) * PERIOD + PERIOD / 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    longint       t;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] ed, input logic eb, input int id);
    exp_t e;
    e.d  = ed;
    e.br = eb;
    e.t  = longint'($time);
    e.id = id;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_diff", e.id), 32'(diff), 32'(e.d));
        chk($sformatf("op%0d_borrow", e.id), 32'(borrow), 32'(e.br));
        chk($sformatf("op%0d_latency", e.id), 32'(longint'($time) - e.t), 32'(LAT_T));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply start for exactly one sampling edge; optionally expect a result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic push, input logic [W-1:0] ed, input logic eb,
                       input int id);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    if (push) push_exp(ed, eb, id);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_diff"}, 32'(diff), 32'd0);
    chk({name, "_borrow"}, 32'(borrow), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic subtraction and latency
    issue(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1);
    chk("busy_after_start", 32'(busy), 32'd1);
    drain("op1");

    // Underflow
    issue(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 2);
    drain("op2");

    // Operand boundaries
    issue(8'h00, 8'hFF, 1'b1, 8'h01, 1'b1, 3);
    drain("op3");
    issue(8'hA5, 8'hA5, 1'b1, 8'h00, 1'b0, 4);
    drain("op4");

    // start ignored mid-SHIFT (edge k+3) and in the DONE state (edge k+9)
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 5);
    tick(2);
    issue(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    tick(5);
    issue(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    tick(1);
    chk("op5_busy_after", 32'(busy), 32'd0);
    chk("op5_done_pulse_width", 32'(done), 32'd0);
    chk("op5_single_done", 32'(sb.size()), 32'd0);
    tick(15);
    chk("op5_still_idle", 32'(busy), 32'd0);

    // Reset aborts an operation at cycle 4; fresh start right after release
    issue(8'h10, 8'h01, 1'b0, 8'h00, 1'b0, 0);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("abort");
    rst_n = 1'b1;
    issue(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 6);
    chk("op6_busy", 32'(busy), 32'd1);
    drain("op6");
    tick(2);

    // Back-to-back with start held high: accepts every W+2 cycles
    a = 8'h0C;
    b = 8'h04;
    start = 1'b1;
    @(posedge clk);
    push_exp(8'h08, 1'b0, 7);
    #1;
    a = 8'h01;
    b = 8'h02;
    repeat (W + 2) @(posedge clk);
    push_exp(8'hFF, 1'b1, 8);
    #1;
    a = 8'h7F;
    b = 8'h7F;
    repeat (W + 2) @(posedge clk);
    push_exp(8'h00, 1'b0, 9);
    #1;
    start = 1'b0;
    drain("b2b");
    tick(1);
    chk("b2b_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress (SHIFT or DONE).
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking diff and borrow as newly valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the registered result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit, the registered final borrow-out (1 iff a < b, unsigned).

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at a clock edge, the block SHALL load a and b into internal shift registers, clear the internal borrow flop, clear the bit counter, and enter SHIFT.
REQ-013 The block SHALL accept start only in IDLE; start in SHIFT or DONE SHALL be ignored without affecting the operation in progress or its operands.
REQ-014 Each SHIFT cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 Each SHIFT cycle SHALL right-shift both operand registers and shift d into the MSB of an internal result register.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of ceil(log2(WIDTH+1)) bits, then transition to DONE.
REQ-017 On entry to DONE, the block SHALL copy the internal result register to diff and the final br to borrow.
REQ-018 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-019 If start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH+1; total latency SHALL be WIDTH+1 cycles.
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; a new start SHALL be accepted at the earliest one cycle after done.
REQ-021 diff and borrow SHALL hold their last values from the DONE update until the next DONE; they SHALL not change during SHIFT.
REQ-022 Operand boundaries SHALL be handled arithmetically: a=b gives diff 0, borrow 0; a=0, b=2^WIDTH-1 gives diff 1, borrow 1.
REQ-023 done, busy, diff and borrow SHALL be driven directly from registers with no combinational path from any input.

Reset
REQ-024 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear busy, done, diff, borrow, the counter, the borrow flop and all shift registers to 0.
REQ-025 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-026 After rst_n returns high, the block SHALL accept start at the first clock edge.

Verification (WIDTH=8)
REQ-027 The bench SHALL apply start with a=0x05, b=0x03; required response: done exactly 9 cycles later, diff=0x02, borrow=0.
REQ-028 The bench SHALL apply start with a=0x03, b=0x05; required response: diff=0xFE, borrow=1.
REQ-029 The bench SHALL apply a=0x00, b=0xFF, then a=0xA5, b=0xA5; required responses: diff=0x01, borrow=1; then diff=0x00, borrow=0.
REQ-030 The bench SHALL start a=0x80, b=0x01, pulse start with a=0xFF, b=0x00 at cycle 3, and again in the DONE cycle; required response: a single done, diff=0x7F, borrow=0, busy low afterwards.
REQ-031 The bench SHALL start a=0x10, b=0x01 and assert rst_n=0 at cycle 4; required response: no done, all outputs 0 next cycle, then a fresh start a=0x10, b=0x01 gives diff=0x0F.
REQ-032 The bench SHALL issue back-to-back ops with start held high continuously; required response: a new operation starts one cycle after each done pulse, and done has period WIDTH+2 cycles.
